// File: rtl/s3g_tx_param_pkg.sv
// Shared S3G framing constants and transmitter state encoding.
// Imported by the transmitter top and the CRC step (the RX side reuses both).
package s3g_tx_param_pkg;

    localparam logic [7:0] S3G_START_BYTE = 8'hD5;
    localparam logic [7:0] S3G_CRC_POLY   = 8'h8C;  // CRC-8/MAXIM, reflected form

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CRC  = 3'd3,
        S_LAST = 3'd4
    } s3g_state_e;

endpackage

// File: rtl/s3g_crc8_step.sv
// One-byte CRC-8/MAXIM update (reflected 0x8C, LSB first), purely combinational.
// Shared between the S3G transmitter and receiver.
module s3g_crc8_step
    import s3g_tx_param_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_s;

    // Eight reflected shift/XOR steps over the byte folded into the CRC
    always_comb begin
        crc_s = crc_in ^ data_in;
        for (int i = 32'sd0; i < 32'sd8; i++) begin
            if (crc_s[0]) begin
                crc_s = (crc_s >> 3'd1) ^ S3G_CRC_POLY;
            end else begin
                crc_s = crc_s >> 3'd1;
            end
        end
        crc_out = crc_s;
    end

endmodule

// File: rtl/s3g_tx_param.sv
// Parametrised S3G packet transmitter: start byte, length, payload, optional CRC-8,
// sent byte-serially to the UART over the tx_wr / tx_done handshake.
module s3g_tx_param
    import s3g_tx_param_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 32,
    parameter logic [7:0] START_BYTE  = S3G_START_BYTE,
    parameter bit         CRC_EN      = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     packet_wr,
    input  logic [7:0]               payload_len,
    input  logic [8*MAX_PAYLOAD-1:0] payload,
    output logic [7:0]               tx_data,
    output logic                     tx_wr,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     packet_done,
    output logic                     packet_err
);

    localparam int         BUF_W   = 8 * MAX_PAYLOAD;
    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

    s3g_state_e       state_r, state_s;
    logic [7:0]       tx_data_r, tx_data_s;
    logic             tx_wr_r, tx_wr_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic [7:0]       len_r, len_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [7:0]       crc_r, crc_s;
    logic [BUF_W-1:0] buf_r, buf_s;
    logic [7:0]       crc_next_s;

    assign tx_data     = tx_data_r;
    assign tx_wr       = tx_wr_r;
    assign busy        = busy_r;
    assign packet_done = done_r;
    assign packet_err  = err_r;

    // The payload is shifted out of buf_r, so the next byte is always at [7:0]
    s3g_crc8_step u_crc (
        .crc_in  (crc_r),
        .data_in (buf_r[7:0]),
        .crc_out (crc_next_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r <= 8'h00;
            tx_wr_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            len_r     <= 8'h00;
            cnt_r     <= 8'h00;
            crc_r     <= 8'h00;
            buf_r     <= {BUF_W{1'b0}};
        end else begin
            tx_data_r <= tx_data_s;
            tx_wr_r   <= tx_wr_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_r     <= err_s;
            len_r     <= len_s;
            cnt_r     <= cnt_s;
            crc_r     <= crc_s;
            buf_r     <= buf_s;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_s   = state_r;
        tx_data_s = tx_data_r;
        tx_wr_s   = 1'b0;
        busy_s    = busy_r;
        done_s    = 1'b0;
        len_s     = len_r;
        cnt_s     = cnt_r;
        crc_s     = crc_r;
        buf_s     = buf_r;

        // Any request outside idle (completion cycle included) is refused
        if (state_r != S_IDLE) begin
            err_s = packet_wr;
        end else begin
            err_s = 1'b0;
        end

        case (state_r)
            S_IDLE: begin
                if (packet_wr) begin
                    if (payload_len > MAX_LEN) begin
                        err_s   = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        buf_s     = payload;
                        len_s     = payload_len;
                        tx_data_s = START_BYTE;
                        tx_wr_s   = 1'b1;
                        busy_s    = 1'b1;
                        state_s   = S_LEN;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (tx_done) begin
                    tx_data_s = len_r;
                    tx_wr_s   = 1'b1;
                    cnt_s     = 8'h00;
                    crc_s     = 8'h00;
                    state_s   = S_DATA;
                end else begin
                    state_s = S_LEN;
                end
            end
            S_DATA: begin
                if (tx_done) begin
                    if (cnt_r < len_r) begin
                        tx_data_s = buf_r[7:0];
                        tx_wr_s   = 1'b1;
                        buf_s     = buf_r >> 4'd8;
                        crc_s     = crc_next_s;
                        cnt_s     = cnt_r + 8'd1;
                        state_s   = S_DATA;
                    end else if (CRC_EN) begin
                        tx_data_s = crc_r;
                        tx_wr_s   = 1'b1;
                        state_s   = S_CRC;
                    end else begin
                        state_s = S_LAST;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
            S_CRC: begin
                if (tx_done) begin
                    state_s = S_LAST;
                end else begin
                    state_s = S_CRC;
                end
            end
            S_LAST: begin
                busy_s  = 1'b0;
                done_s  = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_s3g_tx_param.sv
// Scoreboard bench for s3g_tx_param: one CRC-enabled instance and one CRC-less instance,
// each with a UART responder returning tx_done 3 cycles after every tx_wr.
module tb_s3g_tx_param;

    localparam int MAXP = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              packet_wr, tx_wr, tx_done, busy, packet_done, packet_err;
    logic [7:0]        payload_len, tx_data;
    logic [8*MAXP-1:0] payload;
    logic              packet_wr0, tx_wr0, tx_done0, busy0, packet_done0, packet_err0;
    logic [7:0]        payload_len0, tx_data0;
    logic [8*MAXP-1:0] payload0;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];
    int         evt_q[$];
    int         evt0_q[$];
    int         wr0_cnt = 0;
    int         dly_main = 0;
    int         dly_alt = 0;
    logic [1:0] obs_main, obs_alt;
    logic [8*MAXP-1:0] pl;

    always #5 clk = ~clk;

    s3g_tx_param #(.MAX_PAYLOAD(MAXP), .START_BYTE(8'hD5), .CRC_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .packet_wr(packet_wr), .payload_len(payload_len),
        .payload(payload), .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .busy(busy), .packet_done(packet_done), .packet_err(packet_err)
    );

    s3g_tx_param #(.MAX_PAYLOAD(MAXP), .START_BYTE(8'hD5), .CRC_EN(1'b0)) dut_nocrc (
        .clk(clk), .rst(rst), .packet_wr(packet_wr0), .payload_len(payload_len0),
        .payload(payload0), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_done(tx_done0),
        .busy(busy0), .packet_done(packet_done0), .packet_err(packet_err0)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // UART models: tx_done pulses 3 cycles after each tx_wr
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (rst) begin
                dly_main = 0;
            end else begin
                if (dly_main > 0) begin
                    dly_main--;
                    if (dly_main == 0) tx_done = 1'b1;
                end
                if (tx_wr) dly_main = 2;
            end
        end
    end

    initial begin
        tx_done0 = 1'b0;
        forever begin
            @(negedge clk);
            tx_done0 = 1'b0;
            if (rst) begin
                dly_alt = 0;
            end else begin
                if (dly_alt > 0) begin
                    dly_alt--;
                    if (dly_alt == 0) tx_done0 = 1'b1;
                end
                if (tx_wr0) dly_alt = 2;
            end
        end
    end

    // Monitors: pop the scoreboard whenever a DUT presents a byte or an event
    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr) begin
                chk("main_byte_queued", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) chk("main_byte", tx_data, exp_q.pop_front());
            end
            obs_main = {packet_err, packet_done};
            if (obs_main != 2'b00) begin
                chk("main_evt_queued", (evt_q.size() > 0) ? 1 : 0, 1);
                if (evt_q.size() > 0) chk("main_evt", obs_main, evt_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tx_wr0) begin
                wr0_cnt++;
                chk("alt_byte_queued", (exp0_q.size() > 0) ? 1 : 0, 1);
                if (exp0_q.size() > 0) chk("alt_byte", tx_data0, exp0_q.pop_front());
            end
            obs_alt = {packet_err0, packet_done0};
            if (obs_alt != 2'b00) begin
                chk("alt_evt_queued", (evt0_q.size() > 0) ? 1 : 0, 1);
                if (evt0_q.size() > 0) chk("alt_evt", obs_alt, evt0_q.pop_front());
            end
        end
    end

    task automatic send_main(input logic [7:0] len, input logic [8*MAXP-1:0] data, input bit accept);
        @(negedge clk);
        payload_len = len;
        payload     = data;
        packet_wr   = 1'b1;
        @(negedge clk);
        packet_wr = 1'b0;
        chk("main_first_wr", tx_wr, accept);
        chk("main_busy_on_request", busy, accept);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || evt_q.size() != 0 || exp0_q.size() != 0 ||
                evt0_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 2000) ? 1 : 0, 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_byte(input logic [7:0] b, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clk);
            if (tx_wr && tx_data == b) hit = 1'b1;
            n++;
        end
        chk(name, hit, 1);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        packet_wr = 1'b0;  payload_len = 8'h00;  payload = '0;
        packet_wr0 = 1'b0; payload_len0 = 8'h00; payload0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", packet_done, 0);
        chk("rst_err", packet_err, 0);
        chk("rst_alt_busy", busy0, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "123456789" -> CRC A1
        pl = '0;
        for (int i = 0; i < 9; i++) pl[8*i +: 8] = 8'h31 + 8'(i);
        exp_q.push_back(8'hD5); exp_q.push_back(8'h09);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h31 + 8'(i));
        exp_q.push_back(8'hA1);
        evt_q.push_back(1);
        send_main(8'd9, pl, 1'b1);
        drain("t1_drain");
        chk("t1_busy_after", busy, 0);

        // Zero-length payload
        exp_q.push_back(8'hD5); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        evt_q.push_back(1);
        send_main(8'd0, '0, 1'b1);
        drain("t2_drain");

        // Oversize length is refused
        evt_q.push_back(2);
        send_main(8'd33, '0, 1'b0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("t3_busy_never", seen, 0);
        drain("t3_drain");

        // Request during S_DATA: error pulse, frame 01 02 03 (CRC D8) unaffected
        pl = '0;
        pl[7:0] = 8'h01; pl[15:8] = 8'h02; pl[23:16] = 8'h03;
        exp_q.push_back(8'hD5); exp_q.push_back(8'h03); exp_q.push_back(8'h01);
        exp_q.push_back(8'h02); exp_q.push_back(8'h03); exp_q.push_back(8'hD8);
        evt_q.push_back(2); evt_q.push_back(1);
        send_main(8'd3, pl, 1'b1);
        wait_byte(8'h01, "t4_reach_data");
        @(negedge clk);
        payload_len = 8'd1;
        packet_wr = 1'b1;
        @(negedge clk);
        packet_wr = 1'b0;
        drain("t4_drain");

        // CRC disabled: D5 02 AA 55, exactly four writes
        exp0_q.push_back(8'hD5); exp0_q.push_back(8'h02);
        exp0_q.push_back(8'hAA); exp0_q.push_back(8'h55);
        evt0_q.push_back(1);
        @(negedge clk);
        payload0 = '0;
        payload0[7:0] = 8'hAA; payload0[15:8] = 8'h55;
        payload_len0 = 8'd2;
        packet_wr0 = 1'b1;
        @(negedge clk);
        packet_wr0 = 1'b0;
        drain("t5_drain");
        chk("t5_wr_count", wr0_cnt, 4);

        // Reset right after the length byte aborts the frame
        pl = '0;
        for (int i = 0; i < 4; i++) pl[8*i +: 8] = 8'h10 + 8'(i);
        exp_q.push_back(8'hD5); exp_q.push_back(8'h04);
        send_main(8'd4, pl, 1'b1);
        wait_byte(8'h04, "t6_len_byte");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_tx_wr", tx_wr, 0);
        chk("t6_rst_busy", busy, 0);
        rst = 1'b0;
        chk("t6_queue_empty", exp_q.size(), 0);
        repeat (10) @(negedge clk);
        exp_q.push_back(8'hD5); exp_q.push_back(8'h01);
        exp_q.push_back(8'h01); exp_q.push_back(8'h5E);
        evt_q.push_back(1);
        pl = '0;
        pl[7:0] = 8'h01;
        send_main(8'd1, pl, 1'b1);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s3g_tx_param.md
Name: s3g_tx_param

Overview:
- Parametrised successor of the fixed 16-byte S3G packet transmitter.
- Frames a payload as: start byte, length byte, payload bytes, CRC-8. Emits the frame one byte at a time into the byte-serial UART transmitter, using the tx_wr / tx_done handshake.
- Adds configurable payload depth, a flat payload bus, an optional CRC byte, rejection of oversize lengths, and completion/error pulses.
- Sits between the reply/command assembler and the UART TX.

Parameters:
- MAX_PAYLOAD, 32: payload capacity in bytes, 1..255.
- START_BYTE, 8'hD5: frame start byte.
- CRC_EN, 1: 1 = append CRC byte; 0 = frame ends after the last payload byte.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- packet_wr  in  1  one-cycle request to send the packet on payload/payload_len
- payload_len  in  8  payload byte count
- payload  in  8*MAX_PAYLOAD  payload bytes; byte i is on bits [8i+7:8i]
- tx_data  out  8  byte to the UART
- tx_wr  out  1  one-cycle strobe; tx_data is valid in the same cycle
- tx_done  in  1  one-cycle pulse from the UART: the previously written byte is finished
- busy  out  1  high from acceptance until the frame completes
- packet_done  out  1  one-cycle pulse when the frame completes
- packet_err  out  1  one-cycle pulse on rejected request (oversize, or request while busy)

Behaviour:
- Reset values: tx_data=0, tx_wr=0, busy=0, packet_done=0, packet_err=0, state=S_IDLE, internal counters and CRC cleared.
- Reset mid-frame: abort immediately. No further tx_wr. Latched data is discarded.
- All outputs are registered.
- State machine states: S_IDLE, S_LEN, S_DATA, S_CRC, S_LAST.
- S_IDLE, packet_wr=1, payload_len<=MAX_PAYLOAD:
  - latch payload and payload_len into an internal buffer;
  - next cycle: tx_wr=1, tx_data=START_BYTE, busy=1;
  - go to S_LEN.
- S_IDLE, packet_wr=1, payload_len>MAX_PAYLOAD:
  - packet_err=1 next cycle; remain in S_IDLE; busy stays 0; no bytes sent.
- S_LEN on tx_done:
  - next cycle: tx_wr=1, tx_data=saved length;
  - byte counter=0, crc=0;
  - go to S_DATA.
- S_DATA on tx_done, counter < length:
  - next cycle: tx_data=buffer[counter], tx_wr=1;
  - crc updated with that byte; counter increments.
- S_DATA on tx_done, counter == length:
  - CRC_EN=1: tx_data=crc, tx_wr=1, go to S_CRC.
  - CRC_EN=0: go straight to frame completion (same as S_CRC on tx_done).
- S_CRC on tx_done: go to S_LAST.
- S_LAST:
  - the cycle after entering it: busy=0, packet_done=1;
  - go to S_IDLE.
  - This gives exactly one cycle of packet_done.
- Latency: packet_wr to first tx_wr is 1 cycle. Each tx_done to the next tx_wr is 1 cycle. Final tx_done to packet_done is 2 cycles.
- Zero-length payload: frame is START_BYTE, 0x00, then CRC 0x00 when CRC_EN=1.
- CRC: CRC-8/MAXIM (Dallas/iButton): reflected polynomial 0x8C, init 0x00, no final XOR. It covers payload bytes only, not the start or length bytes.
- Request while busy (any state other than S_IDLE, including the completion cycle): ignored; packet_err=1 next cycle; the frame in progress is unaffected.
- tx_done in S_IDLE: ignored.
- tx_done is never expected in the same cycle as this block's own tx_wr; if it arrives then, it is treated as the done for the previous byte, i.e. it is honoured as a normal done.
- Counter width: 8 bits. Buffer index range is 0..MAX_PAYLOAD-1 and is never exceeded, because length is pre-checked.

Decomposition:
- Shared include s3g_defs.vh:
  - S3G start-byte constant 8'hD5;
  - state encodings;
  - CRC-8/MAXIM polynomial constant.
- One sub-module: s3g_crc8_step, a combinational one-byte CRC-8/MAXIM update (crc_in, data_in -> crc_out). The RX side reuses it.

Test Plan:
- MAX_PAYLOAD=32, payload_len=9, payload "123456789" (0x31..0x39), tx_done returned 3 cycles after each tx_wr -> bytes D5, 09, 31..39, A1; packet_done once; busy low after the final done.
- payload_len=0 -> bytes D5, 00, 00; packet_done once.
- payload_len=33 (MAX_PAYLOAD=32) -> packet_err pulse; busy never rises; no tx_wr.
- packet_wr asserted mid-frame (during S_DATA) -> packet_err pulse; the in-flight frame is byte-exact; no second frame.
- CRC_EN=0, payload_len=2, bytes AA 55 -> D5, 02, AA, 55, then packet_done; exactly 4 tx_wr pulses.
- rst asserted after the length byte -> next cycle tx_wr=0, busy=0; a later packet_wr starts a fresh frame beginning with D5.
